// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage and EX/MEM pipeline register of the 5-stage MIPS core.
//   Applies EX/MEM and MEM/WB forwarding to both operands, performs the ALU
//   operation, and registers the result, store data, destination and memory/WB
//   control into EX/MEM. ALU op 111 is a shift-add multiply that takes
//   MUL_CYCLES+1 cycles and holds upstream via stall_out. flush_in inserts a
//   bubble and cancels any multiply in progress.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   *_in (control/data/regs) ID/EX register outputs
//   memwb_reg_write/rd/data  MEM/WB forwarding source
//   flush_in                 synchronous flush of EX and EX/MEM
//   stall_out                hold PC, IF/ID and ID/EX this cycle
//   *_out                    EX/MEM register contents
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              reg_write_in,
    input  logic              reg_dst_in,
    input  logic              mem_to_reg_in,
    input  logic              ALU_src_in,
    input  logic [2:0]        ALU_op_in,
    input  logic [DATA_W-1:0] read_data1_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [15:0]       imm_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [4:0]        dest_reg_out
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_LUI = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  mcand;      // multiplicand, shifted left each iteration
    logic [DATA_W-1:0]  mplier;     // multiplier, shifted right; bit 0 is the current bit
    logic [DATA_W-1:0]  product;
    logic [DATA_W-1:0]  store_hold; // forwarded rt captured with the mul operands

    logic [DATA_W-1:0]  fwd_a, fwd_b, op_b, alu_y, partial;
    logic [4:0]         dest_sel;

    always_comb begin
        fwd_a = read_data1_in;
        if (reg_write_out && dest_reg_out != 5'd0 && dest_reg_out == rs_in)
            fwd_a = alu_result_out;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs_in)
            fwd_a = memwb_data;

        fwd_b = read_data2_in;
        if (reg_write_out && dest_reg_out != 5'd0 && dest_reg_out == rt_in)
            fwd_b = alu_result_out;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rt_in)
            fwd_b = memwb_data;
    end

    assign op_b     = ALU_src_in ? {{(DATA_W-16){imm_in[15]}}, imm_in} : fwd_b;
    assign dest_sel = reg_dst_in ? rd_in : rt_in;
    assign partial  = product + (mplier[0] ? mcand : '0);

    always_comb begin
        case (ALU_op_in)
            OP_ADD:  alu_y = fwd_a + op_b;
            OP_SUB:  alu_y = fwd_a - op_b;
            OP_AND:  alu_y = fwd_a & op_b;
            OP_OR:   alu_y = fwd_a | op_b;
            OP_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_NOR:  alu_y = ~(fwd_a | op_b);
            OP_LUI:  alu_y = op_b << 16;
            default: alu_y = '0;
        endcase
    end

    // Stall is combinational so upstream freezes in the same cycle the mul is seen.
    always_comb begin
        stall_out = 1'b0;
        if (!rst && !flush_in) begin
            if (state == IDLE)
                stall_out = (ALU_op_in == OP_MUL);
            else
                stall_out = (count != LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            mcand          <= '0;
            mplier         <= '0;
            product        <= '0;
            store_hold     <= '0;
            mem_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
            dest_reg_out   <= '0;
        end else if (flush_in) begin
            state          <= IDLE;
            count          <= '0;
            mem_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ALU_op_in == OP_MUL) begin
                        mcand          <= fwd_a;
                        mplier         <= op_b;
                        product        <= '0;
                        store_hold     <= fwd_b;
                        count          <= '0;
                        state          <= BUSY;
                        mem_write_out  <= 1'b0;
                        mem_read_out   <= 1'b0;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 1'b0;
                    end else begin
                        mem_write_out  <= mem_write_in;
                        mem_read_out   <= mem_read_in;
                        reg_write_out  <= reg_write_in;
                        mem_to_reg_out <= mem_to_reg_in;
                        alu_result_out <= alu_y;
                        store_data_out <= fwd_b;
                        dest_reg_out   <= dest_sel;
                    end
                end
                BUSY: begin
                    product <= partial;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + CNT_W'(1);
                    if (count == LAST) begin
                        // ID/EX is still holding the mul, so its control is current.
                        state          <= IDLE;
                        count          <= '0;
                        mem_write_out  <= mem_write_in;
                        mem_read_out   <= mem_read_in;
                        reg_write_out  <= reg_write_in;
                        mem_to_reg_out <= mem_to_reg_in;
                        alu_result_out <= partial;
                        store_data_out <= store_hold;
                        dest_reg_out   <= dest_sel;
                    end else begin
                        mem_write_out  <= 1'b0;
                        mem_read_out   <= 1'b0;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
